cacheline_adaptor: RTL and testbench

- Responder on the cache's physical-memory line interface: 256-bit read/write requests, single-cycle response.
- Sits between the data cache (or the arbiter above it) and burst DRAM.
- Converts each line transfer into four 64-bit beats on a burst memory port.
- Serialises writes and deserialises reads; one outstanding transaction.

---
 rtl/rv32i_types.sv | 24 ++
 rtl/cacheline_adaptor_checker.sv | 27 ++
 rtl/cacheline_adaptor_line_beat_buffer.sv | 44 ++++
 rtl/cacheline_adaptor.sv | 150 +++++++++++++++
 tb/tb_cacheline_adaptor.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared types and constants for the cacheline adaptor: line/beat geometry,
// the adaptor state encoding and the line-alignment helper.
package rv32i_types;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adaptor_state_t;

    typedef logic [BURST_W-1:0] beat_t;

    // Clear the byte offset within a 32-byte line.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:5], 5'b00000};
    endfunction

endpackage

// File: rtl/cacheline_adaptor_checker.sv
// Protocol checks for the cacheline adaptor, kept out of the datapath.
module cacheline_adaptor_checker (
    input logic clk,
    input logic rst_n,
    input logic in_idle,
    input logic read_i,
    input logic write_i,
    input logic read_o,
    input logic write_o,
    input logic resp_o
);

    // A cache must never ask for a read and a write at the same time;
    // the adaptor resolves it in favour of the write, so this is only flagged.
    ap_single_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_idle && read_i && write_i))
        else $warning("cacheline_adaptor: simultaneous read_i and write_i, write takes priority");

    // The completion pulse is exactly one cycle wide.
    ap_resp_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        resp_o |=> !resp_o);

    // Burst read and burst write requests are mutually exclusive.
    ap_burst_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(read_o && write_o));

endmodule

// File: rtl/cacheline_adaptor_line_beat_buffer.sv
// Four-beat line store: whole-line load for writes, per-beat capture for
// reads, and an indexed read port used to serialise write beats.
module line_beat_buffer
    import rv32i_types::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_en,
    input  logic [LINE_W-1:0]         ld_line,
    input  logic                      wr_en,
    input  logic [1:0]                wr_idx,
    input  beat_t                     wr_data,
    input  logic [1:0]                rd_idx,
    output beat_t                     rd_data,
    output logic [LINE_W-BURST_W-1:0] head_o
);

    beat_t mem_r [BEATS];

    // Beat storage: a full-line load takes priority over a single-beat capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < BEATS; k++) begin
                mem_r[k] <= '0;
            end
        end else if (ld_en) begin
            for (int k = 0; k < BEATS; k++) begin
                mem_r[k] <= ld_line[k*BURST_W +: BURST_W];
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Indexed beat read and the already-captured lower beats of the line.
    always_comb begin
        rd_data = mem_r[rd_idx];
        head_o  = '0;
        for (int k = 0; k < BEATS - 1; k++) begin
            head_o[k*BURST_W +: BURST_W] = mem_r[k];
        end
    end

endmodule

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one 256-bit line read/write from the cache into a
// four-beat 64-bit burst on the memory port, with a single-cycle completion
// pulse back to the cache. One transaction in flight at a time.
module cacheline_adaptor
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    adaptor_state_t             state_r;
    adaptor_state_t             state_next_s;
    logic [1:0]                 cnt_r;
    logic [1:0]                 cnt_next_s;
    logic                       last_beat_s;
    logic                       accept_s;
    logic                       ld_en_s;
    logic                       cap_en_s;
    logic                       rd_last_s;
    logic                       wr_adv_s;
    beat_t                      buf_rd_data_s;
    logic [LINE_W-BURST_W-1:0]  buf_head_s;

    // Datapath strobes derived from the current state and memory handshake.
    always_comb begin
        last_beat_s = (cnt_r == 2'd3);
        accept_s    = (state_r == IDLE) && (read_i || write_i);
        ld_en_s     = (state_r == IDLE) && write_i;
        cap_en_s    = (state_r == RD) && resp_i;
        rd_last_s   = cap_en_s && last_beat_s;
        wr_adv_s    = (state_r == WR) && resp_i && !last_beat_s;
    end

    // Next-state and beat-counter logic; gaps in resp_i simply hold.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_next_s = 2'd0;
                if (write_i) begin
                    state_next_s = WR;
                end else if (read_i) begin
                    state_next_s = RD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD, WR: begin
                if (resp_i) begin
                    cnt_next_s = cnt_r + 2'd1;
                    if (last_beat_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = state_r;
                    end
                end else begin
                    state_next_s = state_r;
                    cnt_next_s   = cnt_r;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                cnt_next_s   = 2'd0;
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 2'd0;
            end
        endcase
    end

    // State and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Registered outputs: request/response strobes follow the next state so
    // they line up with the state they describe; data and address are latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            address_o <= '0;
            burst_o   <= '0;
            line_o    <= '0;
        end else begin
            read_o  <= (state_next_s == RD);
            write_o <= (state_next_s == WR);
            resp_o  <= (state_next_s == DONE);
            if (accept_s) begin
                address_o <= line_align(address_i);
            end
            if (ld_en_s) begin
                burst_o <= line_i[BURST_W-1:0];
            end else if (wr_adv_s) begin
                burst_o <= buf_rd_data_s;
            end
            // The final beat comes straight from the bus so line_o is
            // complete in the same cycle resp_o is raised.
            if (rd_last_s) begin
                line_o <= {burst_i, buf_head_s};
            end
        end
    end

    line_beat_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_en   (ld_en_s),
        .ld_line (line_i),
        .wr_en   (cap_en_s),
        .wr_idx  (cnt_r),
        .wr_data (burst_i),
        .rd_idx  (cnt_r + 2'd1),
        .rd_data (buf_rd_data_s),
        .head_o  (buf_head_s)
    );

    cacheline_adaptor_checker u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_idle (state_r == IDLE),
        .read_i  (read_i),
        .write_i (write_i),
        .read_o  (read_o),
        .write_o (write_o),
        .resp_o  (resp_o)
    );

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: the stimulus pushes expected
// results, a memory responder plays the burst side, and monitors compare.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst_n;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    typedef struct {
        bit           is_read;
        logic [255:0] line;
        logic [31:0]  addr;
    } exp_t;

    exp_t         exp_q[$];
    logic [63:0]  mem_q[$];
    logic [63:0]  wbeat_q[$];
    bit           pat_q[$];
    int           gap_pct;
    bit           stray_en;
    logic [255:0] last_read;
    int           errors;
    int           checks;
    bit           prev_resp;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic bit want_beat();
        if (pat_q.size() > 0) return pat_q.pop_front();
        if (gap_pct == 0) return 1'b1;
        return ($urandom_range(99) >= gap_pct);
    endfunction

    // Memory side: answers burst requests, optionally with wait cycles.
    always begin
        @(posedge clk);
        #1;
        if (read_o) begin
            if (want_beat()) begin
                resp_i = 1'b1;
                if (mem_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL mem_underrun: read beat requested with no data queued");
                    burst_i = 64'd0;
                end else begin
                    burst_i = mem_q.pop_front();
                end
            end else begin
                resp_i  = 1'b0;
                burst_i = {$urandom, $urandom};
            end
        end else if (write_o) begin
            resp_i  = want_beat();
            burst_i = {$urandom, $urandom};
        end else begin
            resp_i  = stray_en ? 1'($urandom_range(1)) : 1'b0;
            burst_i = {$urandom, $urandom};
        end
    end

    // Output monitor: completion, address and write-beat checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_o) begin
                if (prev_resp) begin
                    errors++; checks++;
                    $display("FAIL resp_pulse: resp_o high two cycles in a row");
                end
                chk("done_no_burst_req", {read_o, write_o}, 2'b00);
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL resp_unexpected: resp_o with no transaction outstanding");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(e.is_read ? "read_line" : "line_after_write", line_o, e.line);
                end
            end
            if (read_o || write_o) begin
                if (exp_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL burst_unexpected: read_o=%0b write_o=%0b with nothing issued", read_o, write_o);
                end else begin
                    chk("address_o", address_o, exp_q[0].addr & ~32'h1F);
                end
            end
            if (write_o) begin
                if (wbeat_q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL wbeat_extra: write_o high beyond four beats");
                end else begin
                    chk("write_beat", burst_o, wbeat_q[0]);
                    if (resp_i) void'(wbeat_q.pop_front());
                end
            end
            prev_resp = resp_o;
        end else begin
            prev_resp = 1'b0;
        end
    end

    // Issue one line transaction and wait for its completion pulse.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] rline,
                          output int cyc);
        exp_t e;
        e.is_read = rd && !wr;
        e.addr    = addr;
        if (e.is_read) begin
            for (int k = 0; k < 4; k++) mem_q.push_back(rline[k*64 +: 64]);
            e.line    = rline;
            last_read = rline;
        end else begin
            for (int k = 0; k < 4; k++) wbeat_q.push_back(wline[k*64 +: 64]);
            e.line = last_read;
        end
        exp_q.push_back(e);
        address_i = addr;
        line_i    = wline;
        read_i    = rd;
        write_i   = wr;
        @(posedge clk);
        #1;
        chk("req_latency", {read_o, write_o}, e.is_read ? 2'b10 : 2'b01);
        cyc = 0;
        while (!resp_o && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!resp_o) begin
            errors++; checks++;
            $display("FAIL resp_timeout: no resp_o after %0d cycles", cyc);
        end
        @(posedge clk);
        #1;
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [255:0] l;
        errors = 0; checks = 0; prev_resp = 1'b0;
        gap_pct = 0; stray_en = 1'b0; last_read = '0;
        rst_n = 1'b0; read_i = 1'b0; write_i = 1'b0;
        line_i = '0; address_i = '0; resp_i = 1'b0; burst_i = '0;
        #2;
        chk("rst_resp_o", resp_o, 1'b0);
        chk("rst_read_o", read_o, 1'b0);
        chk("rst_write_o", write_o, 1'b0);
        chk("rst_line_o", line_o, '0);
        chk("rst_burst_o", burst_o, '0);
        chk("rst_address_o", address_o, '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read without gaps, minimum latency.
        do_txn(1'b1, 1'b0, 32'h1234_5678, '0,
               {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}}, cyc);
        chk("read_latency", cyc, 4);

        // Read with a fixed gap pattern.
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_txn(1'b1, 1'b0, 32'h8000_003F, '0, rand_line(), cyc);
        chk("read_gap_latency", cyc, 7);

        // Write with one wait cycle between accepted beats.
        pat_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_txn(1'b0, 1'b1, 32'h0000_1000,
               {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, '0, cyc);
        chk("write_beats_left", wbeat_q.size(), 0);

        // Back-to-back read then write with stray memory handshakes.
        stray_en = 1'b1;
        do_txn(1'b1, 1'b0, 32'hCAFE_0040, '0, rand_line(), cyc);
        do_txn(1'b0, 1'b1, 32'hCAFE_0080, rand_line(), '0, cyc);
        stray_en = 1'b0;

        // Reset in the middle of a read burst.
        begin
            exp_t e;
            e.is_read = 1'b1; e.addr = 32'h0BAD_F00D; e.line = rand_line();
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) mem_q.push_back(e.line[k*64 +: 64]);
        end
        address_i = 32'h0BAD_F00D;
        read_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_read_o", read_o, 1'b0);
        chk("midrst_resp_o", resp_o, 1'b0);
        chk("midrst_line_o", line_o, '0);
        read_i = 1'b0;
        exp_q.delete();
        mem_q.delete();
        last_read = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        l = rand_line();
        do_txn(1'b1, 1'b0, 32'h0BAD_F00D, '0, l, cyc);
        chk("post_rst_latency", cyc, 4);

        // Illegal simultaneous request: the write must be performed.
        do_txn(1'b1, 1'b1, 32'h7777_7777, rand_line(), '0, cyc);

        // Randomised traffic with random wait cycles.
        gap_pct = 30;
        stray_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bit rd;
            rd = 1'($urandom_range(1));
            do_txn(rd, !rd, $urandom, rand_line(), rand_line(), cyc);
        end
        stray_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        chk("wbeat_q_drained", wbeat_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
